// File: rtl/frac_div_pkg.sv
// Shared types and default sizing for the fractional-divider scheduler.
package frac_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int NI_DEF  = 32;
    localparam int NO_DEF  = 40;
    localparam int LAT_DEF = NO_DEF + 2;
    localparam int CNT_W   = $clog2(LAT_DEF + 1);

endpackage

// File: rtl/frac_div_sched_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr_i, circularly.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    logic [IDW:0]    cand;
    logic [NREQ-1:0] onehot;
    logic            found;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        found  = 1'b0;
        cand   = '0;
        onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            onehot = NREQ'(1) << cand;
            if (en_i && !found && |(req_i & onehot)) begin
                found = 1'b1;
                gnt_o = onehot;
                idx_o = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/frac_div_sched.sv
// Shares one fixed-latency fractional divider among NREQ requesters,
// screening divide-by-zero and overflow before the divider is started.
//   state | meaning
//   IDLE  | arbitrating, operands captured on grant
//   CHECK | error screen; start pulse when operands are legal
//   WAIT  | counting out divider latency
//   RESP  | holding response until accepted
module frac_div_sched
    import frac_div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NI   = NI_DEF,
    parameter int NO   = NO_DEF,
    parameter int LAT  = LAT_DEF,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*NI-1:0] req_a,
    input  logic [NREQ*NI-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [NO:0]       rsp_q,
    output logic              rsp_err,
    output logic              busy,
    output logic              div_start,
    output logic [NI-1:0]     div_a,
    output logic [NI-1:0]     div_b,
    input  logic [NO:0]       div_q
);

    localparam int CW = $clog2(LAT + 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, id_q;
    logic [NI-1:0]   a_q, b_q, a_sel, b_sel;
    logic [CW-1:0]   cnt_q;
    logic [NO:0]     q_q;
    logic            err_q;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            chk_err;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                a_sel = req_a[i*NI +: NI];
                b_sel = req_b[i*NI +: NI];
            end
        end
    end

    // Overflow when the quotient integer part would exceed one bit: a >= 2b.
    assign chk_err = (b_q == '0) | ({1'b0, a_q} >= {b_q, 1'b0});

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|gnt) state_d = ST_CHECK;
            ST_CHECK: state_d = chk_err ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = gnt;
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        div_start = (state_q == ST_CHECK) && !chk_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (|gnt) begin
                    a_q   <= a_sel;
                    b_q   <= b_sel;
                    id_q  <= gidx;
                    ptr_q <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
                end
                ST_CHECK: if (chk_err) begin
                    q_q   <= '1;
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= CW'(LAT);
                end
                // Capturing one edge after the divider's nominal latency buys a cycle of margin.
                ST_WAIT: if (cnt_q == '0) begin
                    q_q   <= div_q;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div_a   = a_q;
    assign div_b   = b_q;
    assign rsp_id  = id_q;
    assign rsp_q   = q_q;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_frac_div_sched.sv
// Self-checking bench for frac_div_sched with a behavioural fixed-latency divider.
module tb_frac_div_sched;

    localparam int NREQ = 4;
    localparam int NI   = 32;
    localparam int NO   = 40;
    localparam int LAT  = NO + 2;
    localparam int IDW  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*NI-1:0]    req_a, req_b;
    logic                  rsp_valid, rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [NO:0]           rsp_q;
    logic                  rsp_err, busy, div_start;
    logic [NI-1:0]         div_a, div_b;
    logic [NO:0]           div_q = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_start = 0;

    frac_div_sched #(.NREQ(NREQ), .NI(NI), .NO(NO), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {err, quotient} straight from the arithmetic definition.
    function automatic logic [NO+1:0] ref_div(input logic [NI-1:0] a, input logic [NI-1:0] b);
        logic [127:0] num, quo;
        longint unsigned a64, b64;
        a64 = 64'(a);
        b64 = 64'(b);
        if (b64 == 0 || a64 >= 2 * b64) return {1'b1, {(NO+1){1'b1}}};
        num = 128'(a) << NO;
        quo = num / 128'(b);
        return {1'b0, quo[NO:0]};
    endfunction

    // Divider model: result appears LAT edges after start, then holds; garbage meanwhile.
    logic [NO:0] dv_res = '0;
    int          dv_cnt = 0;
    logic [63:0] junk;
    always @(posedge clk) begin
        junk = {$urandom, $urandom};
        if (div_start) begin
            n_start <= n_start + 1;
            dv_res  <= ref_div(div_a, div_b) [NO:0];
            dv_cnt  <= LAT - 1;
            div_q   <= junk[NO:0];
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
            div_q  <= (dv_cnt == 1) ? dv_res : junk[NO:0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        check({tag, "_req_ready"}, 64'(req_ready), 0);
        check({tag, "_div_start"}, 64'(div_start), 0);
        check({tag, "_busy"},      64'(busy),      0);
        check({tag, "_rsp_q"},     64'(rsp_q),     0);
        check({tag, "_rsp_id"},    64'(rsp_id),    0);
        check({tag, "_rsp_err"},   64'(rsp_err),   0);
        check({tag, "_div_a"},     64'(div_a),     0);
        check({tag, "_div_b"},     64'(div_b),     0);
    endtask

    task automatic do_req(input int id, input logic [NI-1:0] a, input logic [NI-1:0] b,
                          input logic exp_err, input logic [NO:0] exp_q, input int stall);
        int  g, s0, other;
        bit  got;
        s0    = n_start;
        other = (id + 1) % NREQ;
        @(negedge clk);
        req_a[id*NI +: NI] = a;
        req_b[id*NI +: NI] = b;
        req_valid = NREQ'(1) << id;
        rsp_ready = (stall == 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready != 0) got = 1;
            else @(negedge clk);
        end
        check("grant", 64'(req_ready), 64'(NREQ'(1) << id));
        g = cyc;
        @(negedge clk);
        req_valid = '0;
        got = 0;
        for (int i = 0; i < LAT + 10 && !got; i++) begin
            if (rsp_valid) got = 1;
            else @(negedge clk);
        end
        check("rsp_seen", 64'(got), 1);
        check("latency", 64'(cyc - g), exp_err ? 64'd2 : 64'(LAT + 3));
        check("rsp_id", 64'(rsp_id), 64'(id));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_q", 64'(rsp_q), 64'(exp_q));
        if (stall > 0) req_valid = NREQ'(1) << other;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 64'(rsp_valid), 1);
            check("hold_q", 64'(rsp_q), 64'(exp_q));
            check("hold_id", 64'(rsp_id), 64'(id));
            check("hold_noready", 64'(req_ready), 0);
            check("hold_busy", 64'(busy), 1);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("rsp_drop", 64'(rsp_valid), 0);
        check("start_count", 64'(n_start - s0), exp_err ? 64'd0 : 64'd1);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        int            id;
        logic [NI-1:0] a;
        logic [NI-1:0] b;
        logic          err;
        logic [NO:0]   q;
    } vec_t;

    vec_t vecs[7];
    int   rr_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [NO+1:0] r;
        logic [NI-1:0] ra, rb;
        int nresp, ngr, rid;
        bit stale;

        vecs[0] = '{0, 32'h4000_0000, 32'h8000_0000, 1'b0, (NO+1)'(64'h0080_0000_0000)};
        vecs[1] = '{2, 32'h1234_5678, 32'h0000_0000, 1'b1, {(NO+1){1'b1}}};
        vecs[2] = '{1, 32'hC000_0000, 32'h4000_0000, 1'b1, {(NO+1){1'b1}}};
        vecs[3] = '{3, 32'h7FFF_FFFF, 32'h4000_0000, 1'b0, (NO+1)'(64'h01FF_FFFF_FC00)};
        vecs[4] = '{1, 32'h8000_0000, 32'h4000_0000, 1'b1, {(NO+1){1'b1}}};
        vecs[5] = '{0, 32'h0000_0000, 32'h0000_0001, 1'b0, '0};
        vecs[6] = '{3, 32'h0000_0003, 32'h0000_0003, 1'b0, (NO+1)'(64'h0100_0000_0000)};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i])
            do_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].err, vecs[i].q, 0);

        // All requesters valid: grants and responses must rotate 0,1,2,3,0.
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*NI +: NI] = 32'h1000_0000 * (i + 1) + i;
            req_b[i*NI +: NI] = 32'h9000_0000 - i * 32'h0111_1111;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        nresp = 0; ngr = 0;
        for (int t = 0; t < 6 * (LAT + 6) && nresp < 5; t++) begin
            #1;
            if (req_ready != 0 && ngr < 5) begin
                check("rr_grant", 64'(req_ready), 64'(NREQ'(1) << rr_order[ngr]));
                ngr++;
            end
            if (rsp_valid) begin
                rid = rr_order[nresp];
                r = ref_div(req_a[rid*NI +: NI], req_b[rid*NI +: NI]);
                check("rr_id", 64'(rsp_id), 64'(rid));
                check("rr_q", 64'(rsp_q), 64'(r[NO:0]));
                nresp++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rr_count", 64'(nresp), 5);
        @(negedge clk);

        // Back-pressure for 10 cycles while another requester waits.
        r = ref_div(32'h2345_6789, 32'h3000_0001);
        do_req(1, 32'h2345_6789, 32'h3000_0001, r[NO+1], r[NO:0], 10);

        // Reset midway through WAIT abandons the divide.
        @(negedge clk);
        req_a[0 +: NI] = 32'h1111_1111;
        req_b[0 +: NI] = 32'h2222_2223;
        req_valid = 4'b0001;
        stale = 0;
        for (int i = 0; i < 20 && !stale; i++) begin
            #1;
            if (req_ready != 0) stale = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        check("wait_busy", 64'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero_outputs("midreset");
        stale = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1;
        end
        check("no_stale_rsp", 64'(stale), 0);
        r = ref_div(32'h0ABC_DEF0, 32'h1357_9BDF);
        do_req(2, 32'h0ABC_DEF0, 32'h1357_9BDF, r[NO+1], r[NO:0], 0);

        // Randomized single requests against the reference model.
        for (int n = 0; n < 25; n++) begin
            rid = $urandom_range(0, NREQ - 1);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = NI'($urandom_range(1, 255));
                2: ra = ra >> 1;
                default: ;
            endcase
            r = ref_div(ra, rb);
            do_req(rid, ra, rb, r[NO+1], r[NO:0], $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
